// File: rtl/seg_sched_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
package seg_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ON    = 2'd2,
        BLANK = 2'd3
    } state_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Active-low a..g patterns for hex 0-F, dp bit (bit 7) off.
    localparam logic [7:0] SEG_PATTERNS [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex-to-seven-segment decoder with decimal point, active-low outputs.
module seg_hex_decoder
    import seg_sched_pkg::*;
(
    input  logic [3:0] value,
    input  logic       dp_on,
    output logic [7:0] seg
);

    always_comb begin
        seg = {~dp_on, SEG_PATTERNS[value][6:0]};
    end

endmodule

// File: rtl/seg_display_scheduler.sv
// Four-digit common-anode seven-segment scan scheduler with per-frame snapshot and blanking gap.
// Optional duty-cycle dimming via BRIGHTNESS when SEG_SCHED_DIM_EN is defined.
module seg_display_scheduler
    import seg_sched_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] NUMS,
    input  logic [3:0]  DOTS,
    input  logic [3:0]  DIGIT_EN,
`ifdef SEG_SCHED_DIM_EN
    input  logic [3:0]  BRIGHTNESS,
`endif
    output logic [3:0]  SEG_SELECT,
    output logic [7:0]  HEX_OUT,
    output logic        FRAME_TICK
);

    localparam int MAX_CNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] ON_RELOAD    = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_RELOAD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    state_t           state;
    logic [1:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      snap_nums;
    logic [3:0]       snap_dots;
    logic             from_idle;

    logic             found;
    logic [1:0]       next_idx;
    logic [1:0]       cand;
    logic             take_snap;
    logic [15:0]      src_nums;
    logic [3:0]       src_dots;
    logic [3:0]       dec_val;
    logic             dec_dp;
    logic [7:0]       dec_seg;

`ifdef SEG_SCHED_DIM_EN
    logic [3:0]       slice;
    logic [3:0]       slice_nxt;
    logic [3:0]       bright;
    logic [3:0]       an_cur;
`endif

    // Circular search for the next enabled digit; decode from the snapshot
    // that will be in force once this LOAD completes.
    always_comb begin
        found    = 1'b0;
        next_idx = idx;
        cand     = idx;
        for (int k = 1; k <= 4; k++) begin
            cand = idx + 2'(k);
            if (!found && DIGIT_EN[cand]) begin
                found    = 1'b1;
                next_idx = cand;
            end
        end
        take_snap = from_idle || (next_idx <= idx);
        src_nums  = take_snap ? NUMS : snap_nums;
        src_dots  = take_snap ? DOTS : snap_dots;
        dec_val   = src_nums[{next_idx, 2'b00} +: 4];
        dec_dp    = src_dots[next_idx];
    end

    seg_hex_decoder u_dec (
        .value (dec_val),
        .dp_on (dec_dp),
        .seg   (dec_seg)
    );

`ifdef SEG_SCHED_DIM_EN
    always_comb begin
        slice_nxt = slice + 4'd1;
        an_cur    = ~(4'b0001 << idx);
    end
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            idx        <= 2'd3;
            cnt        <= '0;
            snap_nums  <= '0;
            snap_dots  <= '0;
            from_idle  <= 1'b0;
            SEG_SELECT <= AN_OFF;
            HEX_OUT    <= SEG_OFF;
            FRAME_TICK <= 1'b0;
`ifdef SEG_SCHED_DIM_EN
            slice      <= '0;
            bright     <= '0;
`endif
        end else begin
            FRAME_TICK <= 1'b0;
            unique case (state)
                IDLE: begin
                    SEG_SELECT <= AN_OFF;
                    HEX_OUT    <= SEG_OFF;
                    if (DIGIT_EN != 4'd0) begin
                        state     <= LOAD;
                        from_idle <= 1'b1;
                    end
                end
                LOAD: begin
                    from_idle <= 1'b0;
                    if (!found) begin
                        state <= IDLE;
                    end else begin
                        if (take_snap) begin
                            snap_nums  <= NUMS;
                            snap_dots  <= DOTS;
                            FRAME_TICK <= 1'b1;
                        end
                        idx        <= next_idx;
                        cnt        <= ON_RELOAD;
                        state      <= ON;
                        SEG_SELECT <= ~(4'b0001 << next_idx);
                        HEX_OUT    <= dec_seg;
`ifdef SEG_SCHED_DIM_EN
                        slice      <= '0;
                        bright     <= BRIGHTNESS;
`endif
                    end
                end
                ON: begin
                    if (cnt == '0) begin
                        SEG_SELECT <= AN_OFF;
                        HEX_OUT    <= SEG_OFF;
                        if (BLANK_CYCLES == 0) begin
                            state <= LOAD;
                        end else begin
                            state <= BLANK;
                            cnt   <= BLANK_RELOAD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
`ifdef SEG_SCHED_DIM_EN
                        // Anode gated by the slice position; segments stay driven.
                        slice      <= slice_nxt;
                        SEG_SELECT <= (slice_nxt <= bright) ? an_cur : AN_OFF;
`endif
                    end
                end
                BLANK: begin
                    if (cnt == '0) begin
                        state <= LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Scoreboard bench for seg_display_scheduler: each lit digit visit is checked against a queued expectation.
module tb_seg_display_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] nums0, nums1;
    logic [3:0]  dots0, dots1, en0, en1;
    logic [3:0]  sel0, sel1;
    logic [7:0]  hex0, hex1;
    logic        tick0, tick1;

    seg_display_scheduler #(.REFRESH_DIV(4), .BLANK_CYCLES(2)) dut0 (
        .CLK(clk), .RESET(rst), .NUMS(nums0), .DOTS(dots0), .DIGIT_EN(en0),
`ifdef SEG_SCHED_DIM_EN
        .BRIGHTNESS(4'hF),
`endif
        .SEG_SELECT(sel0), .HEX_OUT(hex0), .FRAME_TICK(tick0)
    );

    seg_display_scheduler #(.REFRESH_DIV(4), .BLANK_CYCLES(0)) dut1 (
        .CLK(clk), .RESET(rst), .NUMS(nums1), .DOTS(dots1), .DIGIT_EN(en1),
`ifdef SEG_SCHED_DIM_EN
        .BRIGHTNESS(4'hF),
`endif
        .SEG_SELECT(sel1), .HEX_OUT(hex1), .FRAME_TICK(tick1)
    );

`ifdef SEG_SCHED_DIM_EN
    logic [3:0] en2, bright2, sel2;
    logic [7:0] hex2;
    logic       tick2;
    seg_display_scheduler #(.REFRESH_DIV(32), .BLANK_CYCLES(2)) dut2 (
        .CLK(clk), .RESET(rst), .NUMS(16'h0000), .DOTS(4'h0), .DIGIT_EN(en2),
        .BRIGHTNESS(bright2),
        .SEG_SELECT(sel2), .HEX_OUT(hex2), .FRAME_TICK(tick2)
    );
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int id;
        int an;
        int hex;
        int len;
        int tick;
        int gap;
    } exp_t;

    exp_t sb[$];

    int in_run[2], run_len[2], run_an[2], run_hex[2], run_tick[2], run_gap[2];
    int gap[2], unstable[2], off_tick[2], off_hex_bad[2];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int id, input int an, input int hex, input int len,
                        input int tick, input int gp);
        exp_t e;
        e.id = id; e.an = an; e.hex = hex; e.len = len; e.tick = tick; e.gap = gp;
        sb.push_back(e);
    endtask

    task automatic finish_visit(input int id);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL visit_unexpected: dut%0d anode 0x%0h hex 0x%0h, expected no visit",
                     id, run_an[id], run_hex[id]);
        end else begin
            e = sb.pop_front();
            chk("visit_dut", id, e.id);
            chk("visit_anode", run_an[id], e.an);
            chk("visit_hex", run_hex[id], e.hex);
            chk("visit_len", run_len[id], e.len);
            chk("visit_frame_tick", run_tick[id], e.tick);
            chk("visit_stable", unstable[id], 0);
            if (e.gap >= 0) chk("visit_gap", run_gap[id], e.gap);
        end
    endtask

    task automatic mon(input int id, input logic [3:0] an, input logic [7:0] hex, input logic tick);
        if (an != 4'hF) begin
            if (in_run[id] == 0) begin
                in_run[id]   = 1;
                run_an[id]   = int'(an);
                run_hex[id]  = int'(hex);
                run_len[id]  = 1;
                run_tick[id] = int'(tick);
                run_gap[id]  = gap[id];
                unstable[id] = 0;
            end else begin
                run_len[id]++;
                run_tick[id] += int'(tick);
                if (int'(hex) != run_hex[id] || int'(an) != run_an[id]) unstable[id] = 1;
            end
        end else begin
            if (tick) off_tick[id]++;
            if (hex != 8'hFF) off_hex_bad[id]++;
            if (in_run[id] != 0) begin
                in_run[id] = 0;
                gap[id]    = 1;
                finish_visit(id);
            end else begin
                gap[id]++;
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, sel0, hex0, tick0);
        mon(1, sel1, hex1, tick1);
    end

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int hex_a[4] = '{'hC0, 'h80, 'h88, 'hF9};
    int hex_b[4] = '{'h92, 'h99, 'hB0, 'hA4};

    initial begin
        rst = 1'b1;
        nums0 = 16'h0; dots0 = 4'h0; en0 = 4'h0;
        nums1 = 16'h0; dots1 = 4'h0; en1 = 4'h0;
`ifdef SEG_SCHED_DIM_EN
        en2 = 4'h0; bright2 = 4'hF;
`endif
        repeat (2) @(negedge clk);
        chk("reset_sel0", int'(sel0), 'hF);
        chk("reset_hex0", int'(hex0), 'hFF);
        chk("reset_tick0", int'(tick0), 0);
        chk("reset_sel1", int'(sel1), 'hF);

        // Scan order, tearing, skip, all-off
        nums0 = 16'h1A80; dots0 = 4'h0; en0 = 4'hF;
        for (int v = 0; v < 16; v++) begin
            int d;
            d = (v < 12) ? (v % 4) : ((v % 2) * 2);
            push(0, 15 ^ (1 << d), (v < 8) ? hex_a[d] : hex_b[d], 4,
                 (d == 0) ? 1 : 0, (v == 0) ? -1 : 3);
        end
        pulse_reset();
        repeat (38) @(negedge clk);
        nums0 = 16'h2345;
        repeat (42) @(negedge clk);
        en0 = 4'b0101;
        repeat (28) @(negedge clk);
        en0 = 4'b0000;
        repeat (22) @(negedge clk);
        chk("idle_sel0", int'(sel0), 'hF);
        chk("idle_hex0", int'(hex0), 'hFF);
        chk("phase1_queue_empty", sb.size(), 0);

        // Reset in the middle of an ON slot
        en0 = 4'hF;
        push(0, 'hE, 'h92, 2, 1, -1);
        push(0, 'hE, 'h92, 4, 1, 2);
        push(0, 'hD, 'h99, 4, 0, 3);
        push(0, 'hB, 'hB0, 4, 0, 3);
        push(0, 'h7, 'hA4, 4, 0, 3);
        pulse_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midon_reset_sel0", int'(sel0), 'hF);
        chk("midon_reset_hex0", int'(hex0), 'hFF);
        chk("midon_reset_tick0", int'(tick0), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("after_reset_load_sel0", int'(sel0), 'hF);
        @(negedge clk);
        chk("after_reset_lit_sel0", int'(sel0), 'hE);
        chk("after_reset_lit_hex0", int'(hex0), 'h92);
        chk("after_reset_tick0", int'(tick0), 1);
        repeat (22) @(negedge clk);
        en0 = 4'h0;
        repeat (10) @(negedge clk);
        chk("phase2_idle_sel0", int'(sel0), 'hF);
        chk("phase2_queue_empty", sb.size(), 0);

        // Dots with no blanking gap
        nums1 = 16'h0008; dots1 = 4'b0010; en1 = 4'b0011;
        push(1, 'hE, 'h80, 4, 1, -1);
        push(1, 'hD, 'h40, 4, 0, 1);
        push(1, 'hE, 'h80, 4, 1, 1);
        push(1, 'hD, 'h40, 4, 0, 1);
        pulse_reset();
        repeat (18) @(negedge clk);
        en1 = 4'h0;
        repeat (10) @(negedge clk);
        chk("idle_sel1", int'(sel1), 'hF);
        chk("idle_hex1", int'(hex1), 'hFF);
        chk("phase3_queue_empty", sb.size(), 0);

`ifdef SEG_SCHED_DIM_EN
        begin
            int lit;
            int hbad;
            en2 = 4'h1; bright2 = 4'd3;
            pulse_reset();
            @(negedge clk);
            lit = 0; hbad = 0;
            for (int i = 0; i < 32; i++) begin
                @(negedge clk);
                if (sel2 == 4'hE) lit++;
                if (hex2 != 8'hC0) hbad++;
            end
            chk("dim3_lit_cycles", lit, 8);
            chk("dim3_hex_driven", hbad, 0);
            bright2 = 4'hF;
            repeat (3) @(negedge clk);
            lit = 0;
            for (int i = 0; i < 32; i++) begin
                @(negedge clk);
                if (sel2 == 4'hE) lit++;
            end
            chk("dimF_lit_cycles", lit, 32);
            en2 = 4'h0;
            repeat (5) @(negedge clk);
        end
`endif

        chk("stray_tick_dut0", off_tick[0], 0);
        chk("stray_tick_dut1", off_tick[1], 0);
        chk("blank_hex_dut0", off_hex_bad[0], 0);
        chk("blank_hex_dut1", off_hex_bad[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg_display_scheduler.md
Name: seg_display_scheduler

Overview:
- Time-multiplexes four hex digits onto a common-anode 4-digit seven-segment display.
- Snapshots the digit and decimal-point values once per frame so the display never tears.
- Skips disabled digits and inserts a blanking gap between digits to prevent ghosting.
- Fed by the seven-segment bus interface registers (0xD0/0xD1); drives the display pins directly and emits a frame tick back to the bus side.

Parameters:
- REFRESH_DIV, 100000: CLK cycles each enabled digit is lit per visit; must be at least 1.
- BLANK_CYCLES, 1000: CLK cycles with all anodes off after each digit; 0 removes the BLANK state.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  synchronous, active-high reset.
- NUMS  input  16  packed digit values; NUMS[4x+3:4x] is digit x; x=0 is the rightmost digit.
- DOTS  input  4  decimal point per digit; DOTS[x]=1 lights the dp of digit x.
- DIGIT_EN  input  4  digit enable mask; DIGIT_EN[x]=0 means digit x is never scanned.
- SEG_SELECT  output  4  anodes, active low; SEG_SELECT[x] drives digit x.
- HEX_OUT  output  8  segments, active low; bit0=a ... bit6=g, bit7=dp.
- FRAME_TICK  output  1  one-cycle pulse in each cycle a snapshot is taken.

Behaviour:
- All outputs are registered. Reset values: SEG_SELECT=4'hF, HEX_OUT=8'hFF, FRAME_TICK=0. Reset also clears the state to IDLE, sets the current index to 3, and zeroes the snapshot and counters.
- Reset applies the same way at any point, including mid-ON or mid-BLANK. Outputs blank on the cycle after RESET is sampled high.
- States:
  - IDLE: outputs blank. Moves to LOAD when DIGIT_EN != 0.
  - LOAD (exactly 1 cycle): outputs blank. Searches circularly from index+1 for the next enabled digit.
    - If no digit is enabled: go to IDLE.
    - If the chosen index <= the current index (frame wrap), or LOAD was entered from IDLE: latch NUMS/DOTS into the snapshot and pulse FRAME_TICK.
    - Index <= chosen digit; go to ON.
  - ON: for REFRESH_DIV cycles, SEG_SELECT has only bit[index] low and HEX_OUT = decode(snapshot digit) with dp = ~snapshot dot. Then go to BLANK, or straight to LOAD if BLANK_CYCLES=0.
  - BLANK: all outputs off for BLANK_CYCLES cycles, then go to LOAD.
- Outputs show the new digit on the first ON cycle. Per-digit period is 1 + REFRESH_DIV + BLANK_CYCLES cycles.
- A single enabled digit wraps every visit, so the snapshot updates every visit.
- DIGIT_EN is sampled only in LOAD. Changes during ON/BLANK take effect at the next LOAD, and the current digit completes its slot.
- Changes to NUMS/DOTS between snapshots have no visible effect.
- Decode patterns (dp off) for 0-F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- Phase counter width is clog2(max(REFRESH_DIV, BLANK_CYCLES)+1). The counter reloads on each state entry; it never wraps inside a state.

Optional Feature:
- Macro: SEG_SCHED_DIM_EN.
- Defined: adds input port BRIGHTNESS[3:0]. A 4-bit slice counter clears on ON entry and increments every ON cycle, wrapping mod 16.
  - The anode is asserted only while slice <= BRIGHTNESS, giving a duty of (BRIGHTNESS+1)/16.
  - HEX_OUT stays driven throughout ON.
  - BRIGHTNESS is sampled in LOAD.
- Undefined: no BRIGHTNESS port; the anode is asserted for the whole ON state.

Decomposition:
- Package seg_sched_pkg holds:
  - the state enum (IDLE, LOAD, ON, BLANK);
  - the 16-entry segment pattern constant array;
  - SEG_OFF=8'hFF and AN_OFF=4'hF.
- One sub-module, seg_hex_decoder: combinational, 4-bit value plus dp in, 8-bit active-low segments out.
- The scheduler FSM and counters stay in the top module.

Test Plan:
- Scan order. REFRESH_DIV=4, BLANK_CYCLES=2, DIGIT_EN=F, NUMS=16'h1A80 -> SEG_SELECT cycles E,D,B,7, each low for 4 cycles, with 3 off cycles between. HEX_OUT: 0xC0, 0x80, 0x88, 0xF9 for digits 0-3. Period 28 cycles.
- Tearing. Change NUMS mid-frame -> display unchanged until the next FRAME_TICK, then shows the new values. FRAME_TICK is exactly 1 cycle, once per 28 cycles.
- Skip and all-off. DIGIT_EN=4'b0101 -> only digits 0 and 2 light, period 14. Then DIGIT_EN=0 during ON -> that digit finishes, then IDLE with outputs F/FF.
- Dots and blanking. DOTS=4'b0010, NUMS=16'h0008, BLANK_CYCLES=0 -> digit 1 shows 0x40, digit 0 shows 0x80. No off cycles except the 1-cycle LOAD between digits.
- Reset mid-ON. Assert RESET for 1 cycle -> next cycle SEG_SELECT=F, HEX_OUT=FF, FRAME_TICK=0. After release, digit 0 is lit from the third cycle.
- Dimming (SEG_SCHED_DIM_EN). REFRESH_DIV=32, BRIGHTNESS=3 -> anode low for 4 of every 16 ON cycles (8 of 32 per visit). BRIGHTNESS=F -> low for all 32.
